// File: rtl/hazard_pkg.sv
// Shared encodings and types for the pipeline hazard/forwarding controller.
package hazard_pkg;

  // Execute-stage operand mux selects
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  // ResultSrc encoding that marks a load
  localparam logic [1:0] RES_LOAD = 2'b01;

  // addi x0, x0, 0 -- what the F/D register holds after a flush
  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  // Multi-cycle MDU occupancy state
  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mduState_t;

  // Pick a forwarding source; the youngest producer (Memory) wins over Writeback.
  function automatic logic [1:0] fwdSel(input logic hitM, input logic hitW);
    logic [1:0] sel;
    if (hitM) begin
      sel = FWD_MEM;
    end else if (hitW) begin
      sel = FWD_WB;
    end else begin
      sel = FWD_RF;
    end
    return sel;
  endfunction

endpackage : hazard_pkg

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment and
// the count sticks at all-ones instead of wrapping.
module sat_counter
  import hazard_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  localparam logic [W-1:0] CNT_ZERO = {W{1'b0}};
  localparam logic [W-1:0] CNT_ONE  = {{(W-1){1'b0}}, 1'b1};
  localparam logic [W-1:0] CNT_MAX  = {W{1'b1}};

  // Count register: async reset, sync clear, saturating increment
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= CNT_ZERO;
    end else if (clr) begin
      cnt <= CNT_ZERO;
    end else if (inc && (cnt != CNT_MAX)) begin
      cnt <= cnt + CNT_ONE;
    end else begin
      cnt <= cnt;
    end
  end

endmodule : sat_counter

// File: rtl/hazard_ctrl.sv
// Hazard and forwarding controller for the 5-stage RV32I pipeline.
// Produces Execute-stage forwarding selects plus stall/flush strobes for the
// pipeline registers, covering load-use interlock, branch flush, multi-cycle
// MDU occupancy and (when forwarding is compiled out) RAW interlock.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_AW  = 5,
  parameter int MDU_LAT = 4,
  parameter int EN_FWD  = 1,
  parameter int CNT_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] rs1D,
  input  logic [REG_AW-1:0] rs2D,
  input  logic [REG_AW-1:0] rs1E,
  input  logic [REG_AW-1:0] rs2E,
  input  logic [REG_AW-1:0] rdE,
  input  logic [REG_AW-1:0] rdM,
  input  logic [REG_AW-1:0] rdW,
  input  logic              RegWriteE,
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  input  logic [1:0]        ResultSrcE,
  input  logic              PCSrcE,
  input  logic              mdu_startE,
  input  logic              cnt_clr,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              StallF,
  output logic              StallD,
  output logic              StallE,
  output logic              FlushD,
  output logic              FlushE,
  output logic              FlushM,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam logic [REG_AW-1:0] REG_ZERO  = {REG_AW{1'b0}};
  // The op sits in E for MDU_LAT cycles: one IDLE cycle plus MDU_LAT-1 BUSY
  // cycles, the last of which (mcnt==0) lets it advance.
  localparam logic [3:0]        MCNT_INIT = 4'(MDU_LAT - 2);
  localparam logic              FWD_ON    = (EN_FWD != 0);

  mduState_t   state;
  mduState_t   nextState;
  logic [3:0]  mcnt;
  logic [3:0]  nextMcnt;

  logic        hitMA;
  logic        hitWA;
  logic        hitMB;
  logic        hitWB;
  logic        lwStall;
  logic        rawHit;
  logic        hzStall;
  logic        mduStall;

  // Producer/consumer matches; x0 is never a real producer
  assign hitMA = RegWriteM && (rdM != REG_ZERO) && (rdM == rs1E);
  assign hitWA = RegWriteW && (rdW != REG_ZERO) && (rdW == rs1E);
  assign hitMB = RegWriteM && (rdM != REG_ZERO) && (rdM == rs2E);
  assign hitWB = RegWriteW && (rdW != REG_ZERO) && (rdW == rs2E);

  // A load in E cannot forward in time to the instruction in D
  assign lwStall = (ResultSrcE == RES_LOAD) && (rdE != REG_ZERO) &&
                   ((rdE == rs1D) || (rdE == rs2D));

  // Without forwarding paths, any in-flight E/M writer of a D source must drain
  assign rawHit = (RegWriteE && (rdE != REG_ZERO) && ((rdE == rs1D) || (rdE == rs2D))) ||
                  (RegWriteM && (rdM != REG_ZERO) && ((rdM == rs1D) || (rdM == rs2D)));

  assign hzStall = lwStall || (!FWD_ON && rawHit);

  // The start cycle stalls, then BUSY keeps stalling until the count runs out
  assign mduStall = ((state == IDLE) && mdu_startE) ||
                    ((state == BUSY) && (mcnt != 4'd0));

  // MDU state and down-counter registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      mcnt  <= 4'd0;
    end else begin
      state <= nextState;
      mcnt  <= nextMcnt;
    end
  end

  // MDU next-state: mdu_startE is only looked at in IDLE, since the same op
  // is still presented while BUSY
  always_comb begin
    nextState = state;
    nextMcnt  = mcnt;
    case (state)
      IDLE: begin
        if (mdu_startE) begin
          nextState = BUSY;
          nextMcnt  = MCNT_INIT;
        end else begin
          nextState = IDLE;
          nextMcnt  = 4'd0;
        end
      end
      BUSY: begin
        if (mcnt != 4'd0) begin
          nextState = BUSY;
          nextMcnt  = mcnt - 4'd1;
        end else begin
          nextState = IDLE;
          nextMcnt  = 4'd0;
        end
      end
      default: begin
        nextState = IDLE;
        nextMcnt  = 4'd0;
      end
    endcase
  end

  // Forward selects and prioritised stall/flush strobes; all quiet in reset
  always_comb begin
    ForwardAE = FWD_RF;
    ForwardBE = FWD_RF;
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    FlushM    = 1'b0;
    if (reset) begin
      ForwardAE = FWD_RF;
      ForwardBE = FWD_RF;
    end else begin
      if (FWD_ON) begin
        ForwardAE = fwdSel(hitMA, hitWA);
        ForwardBE = fwdSel(hitMB, hitWB);
      end else begin
        ForwardAE = FWD_RF;
        ForwardBE = FWD_RF;
      end
      if (mduStall) begin
        // No branch can resolve while the MDU op holds E, so PCSrcE is moot
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        FlushM = 1'b1;
      end else if (PCSrcE) begin
        // The hazarding instruction in D is being flushed, so no stall
        FlushD = 1'b1;
        FlushE = 1'b1;
      end else if (hzStall) begin
        StallF = 1'b1;
        StallD = 1'b1;
        FlushE = 1'b1;
      end else begin
        StallF = 1'b0;
        FlushD = 1'b0;
      end
    end
  end

  sat_counter #(.W(CNT_W)) uStallCnt (
    .clk   (clk),
    .reset (reset),
    .inc   (StallF),
    .clr   (cnt_clr),
    .cnt   (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) uFlushCnt (
    .clk   (clk),
    .reset (reset),
    .inc   (FlushD),
    .clr   (cnt_clr),
    .cnt   (flush_cnt)
  );

endmodule : hazard_ctrl

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: a forwarding build with 4-bit counters and
// an interlock-only build, both driven by the same stimulus.
module tb_hazard_ctrl;

  logic       clk;
  logic       reset;
  logic [4:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
  logic       RegWriteE, RegWriteM, RegWriteW;
  logic [1:0] ResultSrcE;
  logic       PCSrcE, mdu_startE, cnt_clr;

  logic [1:0] fwdA0, fwdB0, fwdA1, fwdB1;
  logic       stallF0, stallD0, stallE0, flushD0, flushE0, flushM0;
  logic       stallF1, stallD1, stallE1, flushD1, flushE1, flushM1;
  logic [3:0] stallCnt0, flushCnt0, stallCnt1, flushCnt1;

  int checks;
  int errors;

  hazard_ctrl #(.REG_AW(5), .MDU_LAT(4), .EN_FWD(1), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .rs1D(rs1D), .rs2D(rs2D), .rs1E(rs1E), .rs2E(rs2E),
    .rdE(rdE), .rdM(rdM), .rdW(rdW), .RegWriteE(RegWriteE), .RegWriteM(RegWriteM),
    .RegWriteW(RegWriteW), .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE),
    .mdu_startE(mdu_startE), .cnt_clr(cnt_clr), .ForwardAE(fwdA0), .ForwardBE(fwdB0),
    .StallF(stallF0), .StallD(stallD0), .StallE(stallE0), .FlushD(flushD0),
    .FlushE(flushE0), .FlushM(flushM0), .stall_cnt(stallCnt0), .flush_cnt(flushCnt0)
  );

  hazard_ctrl #(.REG_AW(5), .MDU_LAT(4), .EN_FWD(0), .CNT_W(4)) dutNoFwd (
    .clk(clk), .reset(reset), .rs1D(rs1D), .rs2D(rs2D), .rs1E(rs1E), .rs2E(rs2E),
    .rdE(rdE), .rdM(rdM), .rdW(rdW), .RegWriteE(RegWriteE), .RegWriteM(RegWriteM),
    .RegWriteW(RegWriteW), .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE),
    .mdu_startE(mdu_startE), .cnt_clr(cnt_clr), .ForwardAE(fwdA1), .ForwardBE(fwdB1),
    .StallF(stallF1), .StallD(stallD1), .StallE(stallE1), .FlushD(flushD1),
    .FlushE(flushE1), .FlushM(flushM1), .stall_cnt(stallCnt1), .flush_cnt(flushCnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clearIn();
    rs1D = 5'd0; rs2D = 5'd0; rs1E = 5'd0; rs2E = 5'd0;
    rdE = 5'd0; rdM = 5'd0; rdW = 5'd0;
    RegWriteE = 1'b0; RegWriteM = 1'b0; RegWriteW = 1'b0;
    ResultSrcE = 2'b00; PCSrcE = 1'b0; mdu_startE = 1'b0; cnt_clr = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    clearIn();

    // Reset forces outputs low even with hazards presented
    reset = 1'b1;
    ResultSrcE = 2'b01; RegWriteE = 1'b1; rdE = 5'd7; rs2D = 5'd7;
    RegWriteM = 1'b1; rdM = 5'd5; rs1E = 5'd5; mdu_startE = 1'b1;
    #1;
    chk("rst_stallF", 32'(stallF0), 32'd0);
    chk("rst_flushE", 32'(flushE0), 32'd0);
    chk("rst_stallE", 32'(stallE0), 32'd0);
    chk("rst_fwdA", 32'(fwdA0), 32'd0);
    chk("rst_stall_cnt", 32'(stallCnt0), 32'd0);
    chk("rst_flush_cnt", 32'(flushCnt0), 32'd0);

    // Forwarding from M
    @(negedge clk); reset = 1'b0; clearIn();
    RegWriteM = 1'b1; rdM = 5'd5; rs1E = 5'd5; #1;
    chk("fwd_m_A", 32'(fwdA0), 32'd1);
    chk("fwd_m_B", 32'(fwdB0), 32'd0);
    // M beats W on the same register
    @(negedge clk); RegWriteW = 1'b1; rdW = 5'd5; #1;
    chk("fwd_m_over_w", 32'(fwdA0), 32'd1);
    chk("nofwd_fwdA", 32'(fwdA1), 32'd0);
    // W only, both operands
    @(negedge clk); RegWriteM = 1'b0; rs2E = 5'd5; #1;
    chk("fwd_w_A", 32'(fwdA0), 32'd2);
    chk("fwd_w_B", 32'(fwdB0), 32'd2);
    // x0 never forwards
    @(negedge clk); clearIn(); RegWriteM = 1'b1; RegWriteW = 1'b1; #1;
    chk("fwd_x0_A", 32'(fwdA0), 32'd0);
    chk("fwd_x0_B", 32'(fwdB0), 32'd0);

    // Load-use stall
    @(negedge clk); clearIn();
    ResultSrcE = 2'b01; RegWriteE = 1'b1; rdE = 5'd7; rs2D = 5'd7; #1;
    chk("lw_stallF", 32'(stallF0), 32'd1);
    chk("lw_stallD", 32'(stallD0), 32'd1);
    chk("lw_flushE", 32'(flushE0), 32'd1);
    chk("lw_stallE", 32'(stallE0), 32'd0);
    chk("lw_flushD", 32'(flushD0), 32'd0);
    // Branch taken in the same cycle wins
    @(negedge clk); PCSrcE = 1'b1; #1;
    chk("br_flushD", 32'(flushD0), 32'd1);
    chk("br_flushE", 32'(flushE0), 32'd1);
    chk("br_stallF", 32'(stallF0), 32'd0);
    chk("br_stallD", 32'(stallD0), 32'd0);
    chk("cnt_after_lw", 32'(stallCnt0), 32'd1);
    // Load into x0 is no hazard
    @(negedge clk); clearIn(); ResultSrcE = 2'b01; #1;
    chk("lw_x0_stallF", 32'(stallF0), 32'd0);
    chk("flush_cnt_1", 32'(flushCnt0), 32'd1);
    chk("stall_cnt_1", 32'(stallCnt0), 32'd1);

    // MDU op occupying E for 4 cycles
    @(negedge clk); clearIn(); mdu_startE = 1'b1; #1;
    chk("mdu_c0_stallF", 32'(stallF0), 32'd1);
    chk("mdu_c0_stallE", 32'(stallE0), 32'd1);
    chk("mdu_c0_flushM", 32'(flushM0), 32'd1);
    chk("mdu_c0_flushE", 32'(flushE0), 32'd0);
    @(negedge clk); PCSrcE = 1'b1; #1;
    chk("mdu_c1_stallE", 32'(stallE0), 32'd1);
    chk("mdu_c1_br_ignored", 32'(flushD0), 32'd0);
    @(negedge clk); PCSrcE = 1'b0; #1;
    chk("mdu_c2_stallE", 32'(stallE0), 32'd1);
    @(negedge clk); #1;
    chk("mdu_c3_stallE", 32'(stallE0), 32'd0);
    chk("mdu_c3_stallF", 32'(stallF0), 32'd0);
    chk("mdu_c3_flushM", 32'(flushM0), 32'd0);
    chk("mdu_c3_stall_cnt", 32'(stallCnt0), 32'd4);
    chk("mdu_c3_flush_cnt", 32'(flushCnt0), 32'd1);
    @(negedge clk); #1;
    chk("mdu2_c0_stallE", 32'(stallE0), 32'd1);
    @(negedge clk); #1;
    chk("mdu2_c1_stallE", 32'(stallE0), 32'd1);

    // Reset during BUSY with mcnt=2 abandons the op
    reset = 1'b1; #1;
    chk("rst_busy_stallE", 32'(stallE0), 32'd0);
    chk("rst_busy_stallF", 32'(stallF0), 32'd0);
    chk("rst_busy_flushM", 32'(flushM0), 32'd0);
    chk("rst_busy_stall_cnt", 32'(stallCnt0), 32'd0);
    @(negedge clk); reset = 1'b0; mdu_startE = 1'b0; #1;
    chk("post_rst_stallE", 32'(stallE0), 32'd0);
    @(negedge clk); #1;
    chk("post_rst_stallF", 32'(stallF0), 32'd0);

    // Interlock-only build: RAW on an M writer
    @(negedge clk); clearIn();
    RegWriteM = 1'b1; rdM = 5'd3; rs1D = 5'd3; rs1E = 5'd3; #1;
    chk("raw_m_stallD", 32'(stallD1), 32'd1);
    chk("raw_m_stallF", 32'(stallF1), 32'd1);
    chk("raw_m_flushE", 32'(flushE1), 32'd1);
    chk("raw_m_fwdA", 32'(fwdA1), 32'd0);
    chk("fwd_build_fwdA", 32'(fwdA0), 32'd1);
    chk("fwd_build_stallD", 32'(stallD0), 32'd0);
    // RAW on an E writer (not a load)
    @(negedge clk); clearIn(); RegWriteE = 1'b1; rdE = 5'd4; rs2D = 5'd4; #1;
    chk("raw_e_stallD", 32'(stallD1), 32'd1);
    chk("raw_e_fwd_build", 32'(stallD0), 32'd0);
    // A W writer is not an interlock source
    @(negedge clk); clearIn(); RegWriteW = 1'b1; rdW = 5'd3; rs1D = 5'd3; #1;
    chk("raw_w_stallD", 32'(stallD1), 32'd0);

    // Counter saturation on the 4-bit stall counter
    @(negedge clk); clearIn();
    ResultSrcE = 2'b01; RegWriteE = 1'b1; rdE = 5'd7; rs1D = 5'd7;
    repeat (14) @(negedge clk);
    #1;
    chk("sat_cnt_14", 32'(stallCnt0), 32'd14);
    repeat (6) @(negedge clk);
    #1;
    chk("sat_cnt_15", 32'(stallCnt0), 32'd15);
    chk("sat_flush_cnt", 32'(flushCnt0), 32'd0);
    // Clear beats the still-active increment
    cnt_clr = 1'b1;
    @(negedge clk); #1;
    chk("clr_cnt", 32'(stallCnt0), 32'd0);
    cnt_clr = 1'b0;
    @(negedge clk); #1;
    chk("after_clr_cnt", 32'(stallCnt0), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_hazard_ctrl

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Parametrised hazard and forwarding controller for the 5-stage RV32I pipeline (F/D/E/M/W).
- Generates forwarding selects for the two Execute-stage 3:1 operand muxes, plus all stall and flush strobes for the pipeline registers.
- Adds three things the hazard-free pipeline lacks:
  - load-use interlock;
  - a multi-cycle MDU occupancy FSM;
  - saturating performance counters.
- Optional interlock-only mode for builds without forwarding paths.

Parameters:
- REG_AW, 5, register-address width.
- MDU_LAT, 4, cycles a multi-cycle op occupies E (legal range 2..16).
- EN_FWD, 1, 1 = forwarding enabled; 0 = stall on every RAW hazard.
- CNT_W, 32, performance-counter width.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- rs1D  in  REG_AW  rs1 of the instruction in Decode
- rs2D  in  REG_AW  rs2 of the instruction in Decode
- rs1E  in  REG_AW  rs1 of the instruction in Execute
- rs2E  in  REG_AW  rs2 of the instruction in Execute
- rdE  in  REG_AW  destination register in Execute
- rdM  in  REG_AW  destination register in Memory
- rdW  in  REG_AW  destination register in Writeback
- RegWriteE  in  1  register-write enable in Execute
- RegWriteM  in  1  register-write enable in Memory
- RegWriteW  in  1  register-write enable in Writeback
- ResultSrcE  in  2  result select in Execute; 2'b01 = load
- PCSrcE  in  1  branch taken / jump resolved in Execute
- mdu_startE  in  1  the instruction in Execute is a multi-cycle MDU op
- cnt_clr  in  1  synchronous clear of both counters
- ForwardAE  out  2  operand-A select: 00 RD1E, 01 ALUResultM, 10 WriteDataW
- ForwardBE  out  2  operand-B select, same encoding as ForwardAE
- StallF  out  1  hold PC
- StallD  out  1  hold the F/D register
- StallE  out  1  hold the D/E register
- FlushD  out  1  load NOP (0x00000013) into the F/D register
- FlushE  out  1  bubble into the D/E register
- FlushM  out  1  bubble into the E/M register
- stall_cnt  out  CNT_W  cycles with StallF=1
- flush_cnt  out  CNT_W  cycles with FlushD=1

Behaviour:
- Forwarding (EN_FWD=1), evaluated per operand:
  - select 01 if RegWriteM && rdM!=0 && rdM==rsXE;
  - else 10 if RegWriteW && rdW!=0 && rdW==rsXE;
  - else 00.
  - M has priority over W.
- EN_FWD=0:
  - ForwardAE/BE are tied to 00.
  - rawStall = any RegWriteE/M with rdE/rdM != 0 matching rs1D or rs2D.
  - rawStall is handled exactly like lwStall.
- lwStall = (ResultSrcE==2'b01) && rdE!=0 && (rdE==rs1D || rdE==rs2D).
- MDU FSM, states IDLE and BUSY, with a 4-bit down-counter mcnt:
  - IDLE & mdu_startE: go to BUSY, mcnt <= MDU_LAT-2.
  - BUSY & mcnt!=0: mcnt decrements.
  - BUSY & mcnt==0: return to IDLE.
  - mduStall = (IDLE & mdu_startE) | (BUSY & mcnt!=0).
  - mdu_startE is ignored while in BUSY, because the same instruction is still presented.
  - The MDU op therefore occupies E for exactly MDU_LAT cycles and advances on the last one.
- Output priority, first match wins:
  1. mduStall: StallF=StallD=StallE=1, FlushM=1; PCSrcE is ignored (no branch can be in E).
  2. PCSrcE: FlushD=FlushE=1, no stall; this suppresses any concurrent lwStall/rawStall, since the hazarding instruction is being flushed.
  3. lwStall/rawStall: StallF=StallD=1, FlushE=1.
  4. Otherwise all stall/flush outputs are 0.
- Stall, flush and forward outputs are combinational; only the FSM and the counters are registered.
- While reset=1, all stall/flush/forward outputs are forced to 0.
- Reset state: FSM = IDLE, mcnt=0, stall_cnt=0, flush_cnt=0.
- Reset asserted mid-MDU-op returns the FSM to IDLE immediately (asynchronous); the op is abandoned.
- Counters:
  - +1 per clock with StallF=1 (stall_cnt) or FlushD=1 (flush_cnt).
  - Saturate at all-ones; no wrap.
  - cnt_clr has priority over increment; the counter reads 0 the next cycle.

Decomposition:
- Package hazard_pkg holds:
  - FWD_RF=2'b00, FWD_MEM=2'b01, FWD_WB=2'b10;
  - RES_LOAD=2'b01;
  - NOP_INSTR=32'h00000013;
  - the MDU state enum {IDLE, BUSY}.
- One sub-module, sat_counter (parameter W; inputs inc and clr), instantiated twice.

Test Plan:
- add x5 in M, RegWriteM=1, rs1E=5 -> ForwardAE=01. Same with rdW=5 and rdM=5 -> still 01. rdM=0, RegWriteM=1, rs1E=0 -> 00.
- lw x7 in E (ResultSrcE=01, rdE=7), rs2D=7 -> StallF=StallD=FlushE=1 for one cycle. Add PCSrcE=1 in the same cycle -> FlushD=FlushE=1, StallF=0.
- MDU_LAT=4, mdu_startE held high for 4 cycles -> StallE=FlushM=1 for cycles 0-2, 0 in cycle 3, FSM back in IDLE. Then mdu_startE=1 again in cycle 4 -> new 3-cycle stall.
- EN_FWD=0, RegWriteM=1, rdM=3, rs1D=3 -> StallD=1, ForwardAE=00.
- CNT_W=4, force 20 stall cycles -> stall_cnt=15. Pulse cnt_clr -> stall_cnt=0 next cycle.
- Assert reset during BUSY (mcnt=2) -> all outputs 0 immediately; after release, no stall until a new mdu_startE.
